// File: rtl/hwpe_job_seq_pkg.sv
// Shared types and constants for the HWPE job sequencer.
package hwpe_job_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACQ,
    BACKOFF,
    PROG,
    TRIG,
    WAIT,
    DONE
  } state_e;

  localparam logic [31:0] DEF_ACQUIRE_OFFSET = 32'h04;
  localparam logic [31:0] DEF_TRIGGER_OFFSET = 32'h00;
  localparam logic [31:0] DEF_REG_OFFSET     = 32'h40;

  // HWPE-ctrl acquire returns all-ones when no context is free
  localparam logic [31:0] NO_CONTEXT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0] id;
    logic       err;
  } done_rec_t;

  function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                           input logic [31:0] off,
                                           input logic [31:0] idx);
    return base + off + (idx << 2);
  endfunction

endpackage

// File: rtl/hwpe_job_seq_req_if.sv
// Single-outstanding request/response adapter between the sequencer FSM
// and the HWPE control port.
module hwpe_job_seq_req_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic                 cmd_write,
  input  logic [DataWidth-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [DataWidth-1:0] rsp_data,
  output logic                 pending,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic [AddrWidth-1:0] q_addr,
  output logic                 q_write,
  output logic [DataWidth-1:0] q_data,
  output logic [3:0]           q_strb,
  input  logic                 p_valid,
  input  logic [DataWidth-1:0] p_data
);

  logic hold;

  // command fields are registered in the FSM and stay put until the response,
  // so only the valid needs holding across a stall
  assign q_valid   = cmd_valid | hold;
  assign q_addr    = cmd_addr;
  assign q_write   = cmd_write;
  assign q_data    = cmd_data;
  assign q_strb    = 4'hF;
  assign rsp_valid = pending & p_valid;
  assign rsp_data  = p_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (cmd_valid && !q_ready) hold <= 1'b1;
      else if (q_ready)          hold <= 1'b0;
      if (q_valid && q_ready) pending <= 1'b1;
      else if (p_valid)       pending <= 1'b0;
    end
  end

endmodule

// File: rtl/hwpe_job_sequencer.sv
// HWPE job launcher: acquire, program job registers, trigger, await event.
// Build option HWPE_JOB_SEQ_TIMEOUT_EN adds a WAIT watchdog.
//
// state   | meaning
// IDLE    | ready for a descriptor
// ACQ     | acquire read in flight
// BACKOFF | no free context, retry delay running
// PROG    | writing job register reg_idx
// TRIG    | trigger write in flight
// WAIT    | waiting for the HWPE event
// DONE    | completion record presented
module hwpe_job_sequencer import hwpe_job_seq_pkg::*; #(
  parameter int unsigned NumRegs       = 8,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter logic [31:0] BaseAddr      = 32'h0,
  parameter logic [31:0] AcquireOffset = DEF_ACQUIRE_OFFSET,
  parameter logic [31:0] TriggerOffset = DEF_TRIGGER_OFFSET,
  parameter logic [31:0] RegOffset     = DEF_REG_OFFSET,
  parameter int unsigned RetryDelay    = 16
`ifdef HWPE_JOB_SEQ_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 65536
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [NumRegs*DataWidth-1:0] job_regs_i,
  output logic                         ctrl_q_valid_o,
  input  logic                         ctrl_q_ready_i,
  output logic [AddrWidth-1:0]         ctrl_q_addr_o,
  output logic                         ctrl_q_write_o,
  output logic [DataWidth-1:0]         ctrl_q_data_o,
  output logic [3:0]                   ctrl_q_strb_o,
  input  logic                         ctrl_p_valid_i,
  input  logic [DataWidth-1:0]         ctrl_p_data_i,
  input  logic                         evt_i,
  output logic                         done_valid_o,
  input  logic                         done_ready_i,
  output logic [7:0]                   done_id_o,
  output logic                         done_err_o,
  output logic                         busy_o
);

  localparam int IdxW   = $clog2(NumRegs + 1);
  localparam int RetryW = $clog2(RetryDelay + 1);
  localparam logic [AddrWidth-1:0] AcqAddr  = AddrWidth'(BaseAddr + AcquireOffset);
  localparam logic [AddrWidth-1:0] TrigAddr = AddrWidth'(BaseAddr + TriggerOffset);
`ifdef HWPE_JOB_SEQ_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] wait_cnt;
`endif

  state_e                       state;
  logic [NumRegs*DataWidth-1:0] image;
  logic [IdxW-1:0]              reg_idx;
  logic [RetryW-1:0]            retry_cnt;
  logic                         evt_seen;
  done_rec_t                    rec;
  logic                         cmd_valid, cmd_write;
  logic [AddrWidth-1:0]         cmd_addr;
  logic [DataWidth-1:0]         cmd_data;
  logic                         rsp_valid, pending;
  logic [DataWidth-1:0]         rsp_data;

  hwpe_job_seq_req_if #(.AddrWidth(AddrWidth), .DataWidth(DataWidth)) u_req_if (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_write (cmd_write),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .pending   (pending),
    .q_valid   (ctrl_q_valid_o),
    .q_ready   (ctrl_q_ready_i),
    .q_addr    (ctrl_q_addr_o),
    .q_write   (ctrl_q_write_o),
    .q_data    (ctrl_q_data_o),
    .q_strb    (ctrl_q_strb_o),
    .p_valid   (ctrl_p_valid_i),
    .p_data    (ctrl_p_data_i)
  );

  assign done_id_o  = rec.id;
  assign done_err_o = rec.err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      image        <= '0;
      reg_idx      <= '0;
      retry_cnt    <= '0;
      evt_seen     <= 1'b0;
      rec          <= '0;
      cmd_valid    <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      job_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      done_valid_o <= 1'b0;
`ifdef HWPE_JOB_SEQ_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        IDLE: if (job_valid_i) begin
          image       <= job_regs_i;
          reg_idx     <= '0;
          evt_seen    <= 1'b0;
          rec.err     <= 1'b0;
          job_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          cmd_valid   <= 1'b1;
          cmd_write   <= 1'b0;
          cmd_addr    <= AcqAddr;
          cmd_data    <= '0;
          state       <= ACQ;
        end
        ACQ: if (rsp_valid) begin
          if (rsp_data == NO_CONTEXT) begin
            retry_cnt <= RetryW'(RetryDelay - 1);
            state     <= BACKOFF;
          end else begin
            rec.id    <= rsp_data[7:0];
            cmd_valid <= 1'b1;
            cmd_write <= 1'b1;
            cmd_addr  <= AddrWidth'(reg_addr(BaseAddr, RegOffset, 32'd0));
            cmd_data  <= image[DataWidth-1:0];
            state     <= PROG;
          end
        end
        BACKOFF: begin
          if (retry_cnt == '0) begin
            cmd_valid <= 1'b1;
            cmd_write <= 1'b0;
            cmd_addr  <= AcqAddr;
            cmd_data  <= '0;
            state     <= ACQ;
          end else begin
            retry_cnt <= retry_cnt - RetryW'(1);
          end
        end
        PROG: if (rsp_valid) begin
          reg_idx   <= reg_idx + IdxW'(1);
          cmd_valid <= 1'b1;
          cmd_write <= 1'b1;
          if (reg_idx == IdxW'(NumRegs - 1)) begin
            cmd_addr <= TrigAddr;
            cmd_data <= '0;
            state    <= TRIG;
          end else begin
            cmd_addr <= AddrWidth'(reg_addr(BaseAddr, RegOffset, 32'(reg_idx) + 32'd1));
            cmd_data <= image[DataWidth*(int'(reg_idx) + 1) +: DataWidth];
          end
        end
        TRIG: begin
          // the HWPE may fire before the trigger write is acknowledged
          if (pending && evt_i) evt_seen <= 1'b1;
          if (rsp_valid) begin
            state <= WAIT;
`ifdef HWPE_JOB_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
`ifdef HWPE_JOB_SEQ_TIMEOUT_EN
          if (evt_seen || evt_i) begin
            done_valid_o <= 1'b1;
            state        <= DONE;
          end else if (wait_cnt == CntW'(TimeoutCycles - 1)) begin
            rec.err      <= 1'b1;
            done_valid_o <= 1'b1;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CntW'(1);
          end
`else
          if (evt_seen || evt_i) begin
            done_valid_o <= 1'b1;
            state        <= DONE;
          end
`endif
        end
        DONE: if (done_ready_i) begin
          done_valid_o <= 1'b0;
          job_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_job_sequencer.sv
// Scoreboard bench for hwpe_job_sequencer with a behavioural HWPE control port.
`timescale 1ns/1ps
module tb_hwpe_job_sequencer;

  localparam int NREGS = 8;
  localparam int RETRY = 16;
`ifdef HWPE_JOB_SEQ_TIMEOUT_EN
  localparam int TMO = 100;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               job_valid = 1'b0;
  logic               job_ready;
  logic [NREGS*32-1:0] job_regs = '0;
  logic               ctrl_q_valid;
  logic               ctrl_q_ready = 1'b0;
  logic [31:0]        ctrl_q_addr;
  logic               ctrl_q_write;
  logic [31:0]        ctrl_q_data;
  logic [3:0]         ctrl_q_strb;
  logic               ctrl_p_valid = 1'b0;
  logic [31:0]        ctrl_p_data = '0;
  logic               evt = 1'b0;
  logic               done_valid;
  logic               done_ready = 1'b1;
  logic [7:0]         done_id;
  logic               done_err;
  logic               busy;

  always #5 clk = ~clk;

  hwpe_job_sequencer #(
    .NumRegs(NREGS), .RetryDelay(RETRY)
`ifdef HWPE_JOB_SEQ_TIMEOUT_EN
    , .TimeoutCycles(TMO)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_regs_i(job_regs),
    .ctrl_q_valid_o(ctrl_q_valid), .ctrl_q_ready_i(ctrl_q_ready),
    .ctrl_q_addr_o(ctrl_q_addr), .ctrl_q_write_o(ctrl_q_write),
    .ctrl_q_data_o(ctrl_q_data), .ctrl_q_strb_o(ctrl_q_strb),
    .ctrl_p_valid_i(ctrl_p_valid), .ctrl_p_data_i(ctrl_p_data),
    .evt_i(evt),
    .done_valid_o(done_valid), .done_ready_i(done_ready),
    .done_id_o(done_id), .done_err_o(done_err), .busy_o(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } req_t;

  req_t        exp_req[$];
  logic [8:0]  exp_done[$];
  logic [31:0] acq_rsp[$];

  int total = 0, bad = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0;
  int trig_rsp_cyc = 0, done_rise_cyc = 0;
  int stall_cfg = 0, pdly_cfg = 0, evt_after = 0;
  bit evt_prog = 1'b0;
  int kick_req = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // HWPE control port model: stalls, delayed responses, acquire data, events
  bit          pend = 1'b0;
  int          pcnt = 0, stall_n = 0, evt_cnt = 0, kick_ack = 0;
  logic [31:0] pdata = '0;
  always @(negedge clk) begin
    ctrl_p_valid = 1'b0;
    evt          = 1'b0;
    ctrl_q_ready = 1'b0;
    if (!rst_n) begin
      pend = 1'b0; stall_n = 0; evt_cnt = 0; kick_ack = kick_req;
    end else begin
      if (kick_req != kick_ack) begin evt = 1'b1; kick_ack = kick_req; end
      if (evt_cnt > 0) begin evt_cnt--; if (evt_cnt == 0) evt = 1'b1; end
      if (pend) begin
        if (pcnt == 0) begin ctrl_p_valid = 1'b1; ctrl_p_data = pdata; pend = 1'b0; end
        else pcnt--;
      end
      if (ctrl_q_valid) begin
        if (stall_n < stall_cfg) stall_n++;
        else begin
          ctrl_q_ready = 1'b1; stall_n = 0; pend = 1'b1; pcnt = pdly_cfg;
          pdata = 32'h0;
          if (!ctrl_q_write && acq_rsp.size() > 0) pdata = acq_rsp.pop_front();
          if (ctrl_q_write && ctrl_q_addr == 32'h0 && evt_after > 0) evt_cnt = evt_after;
          if (ctrl_q_write && ctrl_q_addr == 32'h40 && evt_prog) evt_cnt = 1;
        end
      end
    end
  end

  // monitor / scoreboard
  bit          outst = 1'b0, outst_rd = 1'b0, outst_trig = 1'b0;
  bit          prev_stall = 1'b0, prev_qv = 1'b0, last_fail = 1'b0, prev_done = 1'b0;
  int          last_rsp_cyc = 0;
  logic [64:0] prev_fields = '0, cur_fields;
  req_t        e;
  logic [8:0]  ed;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      outst = 1'b0; prev_stall = 1'b0; prev_qv = 1'b0; last_fail = 1'b0; prev_done = 1'b0;
    end else begin
      cur_fields = {ctrl_q_addr, ctrl_q_write, ctrl_q_data};
      if (prev_stall) begin
        check("q_hold_valid", ctrl_q_valid, 1);
        check("q_hold_fields", cur_fields, prev_fields);
      end
      if (ctrl_q_valid && !prev_qv && last_fail) begin
        check("retry_gap", cyc - last_rsp_cyc - 1, RETRY);
        last_fail = 1'b0;
      end
      if (ctrl_p_valid && outst) begin
        last_rsp_cyc = cyc;
        last_fail    = outst_rd && (ctrl_p_data == 32'hFFFF_FFFF);
        if (outst_trig) trig_rsp_cyc = cyc;
        outst = 1'b0;
      end
      if (ctrl_q_valid && ctrl_q_ready) begin
        check("single_outstanding", outst, 0);
        check("q_strb", ctrl_q_strb, 4'hF);
        if (exp_req.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected: got addr %0h write %0b", ctrl_q_addr, ctrl_q_write);
        end else begin
          e = exp_req.pop_front();
          check("req_addr", ctrl_q_addr, e.addr);
          check("req_write", ctrl_q_write, e.wr);
          if (e.wr) check("req_data", ctrl_q_data, e.data);
        end
        outst = 1'b1; outst_rd = !ctrl_q_write;
        outst_trig = ctrl_q_write && ctrl_q_addr == 32'h0;
        hs_cnt++;
      end
      prev_stall  = ctrl_q_valid && !ctrl_q_ready;
      prev_fields = cur_fields;
      prev_qv     = ctrl_q_valid;
      if (done_valid && !prev_done) done_rise_cyc = cyc;
      prev_done = done_valid;
      if (done_valid && done_ready) begin
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got id %0h err %0b", done_id, done_err);
        end else begin
          ed = exp_done.pop_front();
          check("done_rec", {done_id, done_err}, ed);
        end
        done_cnt++;
      end
    end
  end

  task automatic push_job(input logic [7:0] id, input bit err, input int nfail,
                          input logic [31:0] base);
    for (int i = 0; i <= nfail; i++) exp_req.push_back('{32'h4, 1'b0, 32'h0});
    for (int i = 0; i < nfail; i++) acq_rsp.push_back(32'hFFFF_FFFF);
    acq_rsp.push_back({24'h0, id});
    for (int i = 0; i < NREGS; i++) begin
      job_regs[32*i +: 32] = base + 32'(i);
      exp_req.push_back('{32'h40 + 32'(4*i), 1'b1, base + 32'(i)});
    end
    exp_req.push_back('{32'h0, 1'b1, 32'h0});
    exp_done.push_back({id, err});
  endtask

  task automatic start_job();
    int n = 0;
    while (!job_ready && n < 200) begin @(negedge clk); n++; end
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    check("accept_to_q_valid", ctrl_q_valid, 1);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    check(name, done_cnt, target);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_job_ready"}, job_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_q_valid"}, ctrl_q_valid, 0);
    check({tag, "_q_addr"}, ctrl_q_addr, 0);
    check({tag, "_q_write"}, ctrl_q_write, 0);
    check({tag, "_q_data"}, ctrl_q_data, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_done_id"}, done_id, 0);
    check({tag, "_done_err"}, done_err, 0);
  endtask

  initial begin
    int n;
    int h0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);

    // basic job
    evt_after = 10;
    push_job(8'h03, 1'b0, 0, 32'hA000_0000);
    start_job();
    wait_done(1, 300, "basic_done");

    // two busy acquires then success
    push_job(8'h01, 1'b0, 2, 32'hB000_0010);
    start_job();
    wait_done(2, 400, "acq_busy_done");

    // control-port backpressure and slow responses
    stall_cfg = 3; pdly_cfg = 2;
    push_job(8'h07, 1'b0, 0, 32'hC000_0100);
    start_job();
    wait_done(3, 600, "backpressure_done");
    stall_cfg = 0;

    // event before the trigger response
    evt_after = 1;
    push_job(8'h22, 1'b0, 0, 32'hD000_0000);
    start_job();
    wait_done(4, 400, "early_evt_done");
    pdly_cfg = 0;

    // event during programming must be ignored
    evt_after = 0; evt_prog = 1'b1;
    push_job(8'h33, 1'b0, 0, 32'hE000_0000);
    start_job();
    repeat (80) @(negedge clk);
    check("prog_evt_no_done", done_valid, 0);
    check("prog_evt_still_busy", busy, 1);
    evt_prog = 1'b0;
    kick_req++;
    wait_done(5, 50, "late_evt_done");

    // completion backpressure, then simultaneous done_ready/job_valid
    evt_after = 10; done_ready = 1'b0;
    push_job(8'h05, 1'b0, 0, 32'hF000_0000);
    start_job();
    n = 0;
    while (!done_valid && n < 300) begin @(negedge clk); n++; end
    check("done_bp_seen", done_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("done_bp_valid", done_valid, 1);
      check("done_bp_id", done_id, 8'h05);
      check("done_bp_job_ready", job_ready, 0);
    end
    push_job(8'h06, 1'b0, 0, 32'h1234_0000);
    done_ready = 1'b1; job_valid = 1'b1;
    @(negedge clk);
    check("no_accept_with_done_busy", busy, 0);
    check("no_accept_with_done_ready", job_ready, 1);
    @(negedge clk);
    job_valid = 1'b0;
    check("accept_after_done_q_valid", ctrl_q_valid, 1);
    wait_done(7, 300, "after_done_job");

    // reset during PROG
    push_job(8'h09, 1'b0, 0, 32'h5555_0000);
    h0 = hs_cnt;
    start_job();
    n = 0;
    while (hs_cnt < h0 + 3 && n < 200) begin @(negedge clk); n++; end
    check("reached_prog", hs_cnt >= h0 + 3, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    exp_req.delete(); acq_rsp.delete(); exp_done.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_job(8'h0A, 1'b0, 0, 32'h6666_0000);
    start_job();
    wait_done(8, 300, "post_reset_done");

`ifdef HWPE_JOB_SEQ_TIMEOUT_EN
    evt_after = 0;
    push_job(8'h0B, 1'b1, 0, 32'h7777_0000);
    start_job();
    wait_done(9, 400, "timeout_done");
    check("timeout_latency", done_rise_cyc - (trig_rsp_cyc + 1), TMO);

    evt_after = TMO + 1;
    push_job(8'h0C, 1'b0, 0, 32'h8888_0000);
    start_job();
    wait_done(10, 400, "evt_at_limit_done");
    check("evt_at_limit_latency", done_rise_cyc - (trig_rsp_cyc + 1), TMO);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
